// File: rtl/dof_pkg.sv
// dof_pkg: shared constants for the decode/operand-fetch stage.
// Holds the packed layout of the decoder control word (ctrl_in) and the
// memory-data select encoding that marks a load in the execute stage.
// Control word layout, MSB first: RW, DA, MD, BS, PS, MW, FS, MA, MB, CS, AA, BA.
package dof_pkg;
    localparam int CTRL_REG_W = 5;   // DA / AA / BA width inside the control word
    localparam int MD_W       = 2;
    localparam int BS_W       = 2;
    localparam int FS_W       = 5;

    localparam int BA_LSB = 0;
    localparam int AA_LSB = BA_LSB + CTRL_REG_W;   // 5
    localparam int CS_BIT = AA_LSB + CTRL_REG_W;   // 10
    localparam int MB_BIT = CS_BIT + 1;            // 11
    localparam int MA_BIT = MB_BIT + 1;            // 12
    localparam int FS_LSB = MA_BIT + 1;            // 13
    localparam int MW_BIT = FS_LSB + FS_W;         // 18
    localparam int PS_BIT = MW_BIT + 1;            // 19
    localparam int BS_LSB = PS_BIT + 1;            // 20
    localparam int MD_LSB = BS_LSB + BS_W;         // 22
    localparam int DA_LSB = MD_LSB + MD_W;         // 24
    localparam int RW_BIT = DA_LSB + CTRL_REG_W;   // 29
    localparam int CTRL_BITS = RW_BIT + 1;         // 30

    localparam logic [MD_W-1:0] MD_LOAD = 2'b01;
endpackage

// File: rtl/dof_operand_mux.sv
// dof_operand_mux: selects one operand for the stage.
// Priority: alternate source (PC or immediate) > EX-stage result (non-load)
// > WB-stage result > register-file read data. Register 0 is never forwarded.
// Ports:
//   sel_alt_i/alt_i        alternate source select and value
//   addr_i/rdata_i         register address and register-file read data
//   ex_rw_i/ex_da_i/ex_md_i/ex_result_i  execute-stage writeback info
//   wb_rw_i/wb_da_i/wb_result_i          writeback-stage info
//   operand_o              selected operand
module dof_operand_mux
    import dof_pkg::*;
#(
    parameter int DATA_BITS     = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     sel_alt_i,
    input  logic [DATA_BITS-1:0]     alt_i,
    input  logic [REG_ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0]     rdata_i,
    input  logic                     ex_rw_i,
    input  logic [REG_ADDR_BITS-1:0] ex_da_i,
    input  logic [MD_W-1:0]          ex_md_i,
    input  logic [DATA_BITS-1:0]     ex_result_i,
    input  logic                     wb_rw_i,
    input  logic [REG_ADDR_BITS-1:0] wb_da_i,
    input  logic [DATA_BITS-1:0]     wb_result_i,
    output logic [DATA_BITS-1:0]     operand_o
);
    logic addr_nz;
    logic ex_hit;
    logic wb_hit;

    assign addr_nz = (addr_i != '0);
    // A load in EX has no data yet; that case is handled by the load-use bubble.
    assign ex_hit  = ex_rw_i && (ex_da_i == addr_i) && addr_nz && (ex_md_i != MD_LOAD);
    assign wb_hit  = wb_rw_i && (wb_da_i == addr_i) && addr_nz;

    always_comb begin
        operand_o = rdata_i;
        if (sel_alt_i)   operand_o = alt_i;
        else if (ex_hit) operand_o = ex_result_i;
        else if (wb_hit) operand_o = wb_result_i;
    end
endmodule

// File: rtl/dof_stage.sv
// dof_stage: decode/operand-fetch pipeline stage.
// Builds operands A and B with EX/WB forwarding, extends the immediate,
// detects load-use hazards and registers all fields for the execute stage.
// Handshake: an instruction is accepted on a rising edge when in_valid and
// in_ready are both high; in_ready = !stall_in && !load_use_stall.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake
//   instruction, pc_min_one raw instruction and its PC
//   ctrl_in                 packed decoder fields (layout in dof_pkg)
//   AData, BData            register-file read data
//   ex_*, wb_*              forwarding sources
//   flush, stall_in         kill / downstream hold
//   AA, BA                  combinational register-file read addresses
//   out_valid, pc_min_two, RW..BUSB  registered pipeline outputs
//   load_use_stall          combinational bubble request
//   bubble_count            saturating count of issued bubbles
module dof_stage
    import dof_pkg::*;
#(
    parameter int DATA_BITS        = 32,
    parameter int INSTRUCTION_BITS = 32,
    parameter int REG_ADDR_BITS    = 5,
    parameter int IMM_BITS         = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTRUCTION_BITS-1:0] instruction,
    input  logic [DATA_BITS-1:0]        pc_min_one,
    input  logic [CTRL_BITS-1:0]        ctrl_in,
    input  logic [DATA_BITS-1:0]        AData,
    input  logic [DATA_BITS-1:0]        BData,
    input  logic                        ex_RW,
    input  logic [REG_ADDR_BITS-1:0]    ex_DA,
    input  logic [MD_W-1:0]             ex_MD,
    input  logic [DATA_BITS-1:0]        ex_result,
    input  logic                        wb_RW,
    input  logic [REG_ADDR_BITS-1:0]    wb_DA,
    input  logic [DATA_BITS-1:0]        wb_result,
    input  logic                        flush,
    input  logic                        stall_in,
    output logic [REG_ADDR_BITS-1:0]    AA,
    output logic [REG_ADDR_BITS-1:0]    BA,
    output logic                        out_valid,
    output logic [DATA_BITS-1:0]        pc_min_two,
    output logic                        RW,
    output logic [REG_ADDR_BITS-1:0]    DA,
    output logic [MD_W-1:0]             MD,
    output logic [BS_W-1:0]             BS,
    output logic                        PS,
    output logic                        MW,
    output logic [FS_W-1:0]             FS,
    output logic [REG_ADDR_BITS-1:0]    SH,
    output logic [DATA_BITS-1:0]        BUSA,
    output logic [DATA_BITS-1:0]        BUSB,
    output logic                        load_use_stall,
    output logic [15:0]                 bubble_count
);
    // Decoded control fields
    logic                     c_rw, c_ps, c_mw, c_ma, c_mb, c_cs;
    logic [REG_ADDR_BITS-1:0] c_da;
    logic [MD_W-1:0]          c_md;
    logic [BS_W-1:0]          c_bs;
    logic [FS_W-1:0]          c_fs;

    assign c_rw = ctrl_in[RW_BIT];
    assign c_da = ctrl_in[DA_LSB +: REG_ADDR_BITS];
    assign c_md = ctrl_in[MD_LSB +: MD_W];
    assign c_bs = ctrl_in[BS_LSB +: BS_W];
    assign c_ps = ctrl_in[PS_BIT];
    assign c_mw = ctrl_in[MW_BIT];
    assign c_fs = ctrl_in[FS_LSB +: FS_W];
    assign c_ma = ctrl_in[MA_BIT];
    assign c_mb = ctrl_in[MB_BIT];
    assign c_cs = ctrl_in[CS_BIT];
    assign AA   = ctrl_in[AA_LSB +: REG_ADDR_BITS];
    assign BA   = ctrl_in[BA_LSB +: REG_ADDR_BITS];

    // Upper instruction bits carry opcode only; decoding happened upstream.
    logic unused_opcode;
    assign unused_opcode = ^instruction[INSTRUCTION_BITS-1:IMM_BITS];

    logic [IMM_BITS-1:0]  imm;
    logic [DATA_BITS-1:0] imm_ext;
    assign imm     = instruction[IMM_BITS-1:0];
    assign imm_ext = c_cs ? {{(DATA_BITS-IMM_BITS){imm[IMM_BITS-1]}}, imm}
                          : {{(DATA_BITS-IMM_BITS){1'b0}}, imm};

    logic [DATA_BITS-1:0] opa, opb;

    dof_operand_mux #(.DATA_BITS(DATA_BITS), .REG_ADDR_BITS(REG_ADDR_BITS)) u_mux_a (
        .sel_alt_i(c_ma), .alt_i(pc_min_one), .addr_i(AA), .rdata_i(AData),
        .ex_rw_i(ex_RW), .ex_da_i(ex_DA), .ex_md_i(ex_MD), .ex_result_i(ex_result),
        .wb_rw_i(wb_RW), .wb_da_i(wb_DA), .wb_result_i(wb_result),
        .operand_o(opa)
    );

    dof_operand_mux #(.DATA_BITS(DATA_BITS), .REG_ADDR_BITS(REG_ADDR_BITS)) u_mux_b (
        .sel_alt_i(c_mb), .alt_i(imm_ext), .addr_i(BA), .rdata_i(BData),
        .ex_rw_i(ex_RW), .ex_da_i(ex_DA), .ex_md_i(ex_MD), .ex_result_i(ex_result),
        .wb_rw_i(wb_RW), .wb_da_i(wb_DA), .wb_result_i(wb_result),
        .operand_o(opb)
    );

    // A register source that is actually read (not replaced by PC/immediate)
    // and is the target of a load still in EX must wait one cycle.
    assign load_use_stall = in_valid && ex_RW && (ex_MD == MD_LOAD) && (ex_DA != '0) &&
                            (((ex_DA == AA) && !c_ma) || ((ex_DA == BA) && !c_mb));
    assign in_ready = !stall_in && !load_use_stall;

    logic                     valid_q, rw_q, ps_q, mw_q;
    logic [DATA_BITS-1:0]     pc_q, busa_q, busb_q;
    logic [REG_ADDR_BITS-1:0] da_q, sh_q;
    logic [MD_W-1:0]          md_q;
    logic [BS_W-1:0]          bs_q;
    logic [FS_W-1:0]          fs_q;
    logic [15:0]              cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0; rw_q <= 1'b0; ps_q <= 1'b0; mw_q <= 1'b0;
            pc_q <= '0; busa_q <= '0; busb_q <= '0;
            da_q <= '0; sh_q <= '0; md_q <= '0; bs_q <= '0; fs_q <= '0;
            cnt_q <= 16'd0;
        end else if (flush) begin
            valid_q <= 1'b0; rw_q <= 1'b0; mw_q <= 1'b0;
        end else if (stall_in) begin
            // hold every output register
        end else if (load_use_stall) begin
            valid_q <= 1'b0; rw_q <= 1'b0; mw_q <= 1'b0;
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end else begin
            valid_q <= in_valid;
            rw_q    <= in_valid && c_rw;
            mw_q    <= in_valid && c_mw;
            pc_q    <= pc_min_one;
            da_q    <= c_da;
            md_q    <= c_md;
            bs_q    <= c_bs;
            ps_q    <= c_ps;
            fs_q    <= c_fs;
            sh_q    <= instruction[REG_ADDR_BITS-1:0];
            busa_q  <= opa;
            busb_q  <= opb;
        end
    end

    assign out_valid    = valid_q;
    assign pc_min_two   = pc_q;
    assign RW           = rw_q;
    assign DA           = da_q;
    assign MD           = md_q;
    assign BS           = bs_q;
    assign PS           = ps_q;
    assign MW           = mw_q;
    assign FS           = fs_q;
    assign SH           = sh_q;
    assign BUSA         = busa_q;
    assign BUSB         = busb_q;
    assign bubble_count = cnt_q;
endmodule

// File: tb/tb_dof_stage.sv
// tb_dof_stage: directed scenarios followed by randomized traffic, all checked
// against a reference model that applies the stage's rules directly.
module tb_dof_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction, pc_min_one, AData, BData;
    logic [29:0] ctrl_in;
    logic        ex_RW, wb_RW, flush, stall_in;
    logic [4:0]  ex_DA, wb_DA;
    logic [1:0]  ex_MD;
    logic [31:0] ex_result, wb_result;
    logic [4:0]  AA, BA, DA, SH;
    logic        out_valid, RW, PS, MW, load_use_stall;
    logic [31:0] pc_min_two, BUSA, BUSB;
    logic [1:0]  MD, BS;
    logic [4:0]  FS;
    logic [15:0] bubble_count;

    // control fields, packed into ctrl_in by pack_ctrl()
    logic       c_rw, c_ps, c_mw, c_ma, c_mb, c_cs;
    logic [4:0] c_da, c_fs, c_aa, c_ba;
    logic [1:0] c_md, c_bs;

    // reference model state
    logic        m_valid, m_rw, m_mw, m_ps, m_known;
    logic [31:0] m_pc, m_busa, m_busb;
    logic [4:0]  m_da, m_fs, m_sh;
    logic [1:0]  m_md, m_bs;
    int          m_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dof_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_min_one(pc_min_one), .ctrl_in(ctrl_in),
        .AData(AData), .BData(BData),
        .ex_RW(ex_RW), .ex_DA(ex_DA), .ex_MD(ex_MD), .ex_result(ex_result),
        .wb_RW(wb_RW), .wb_DA(wb_DA), .wb_result(wb_result),
        .flush(flush), .stall_in(stall_in), .AA(AA), .BA(BA),
        .out_valid(out_valid), .pc_min_two(pc_min_two), .RW(RW), .DA(DA), .MD(MD),
        .BS(BS), .PS(PS), .MW(MW), .FS(FS), .SH(SH), .BUSA(BUSA), .BUSB(BUSB),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_ctrl();
        ctrl_in = {c_rw, c_da, c_md, c_bs, c_ps, c_mw, c_fs, c_ma, c_mb, c_cs, c_aa, c_ba};
    endtask

    task automatic clear_inputs();
        in_valid = 1'b1; instruction = 32'h0; pc_min_one = 32'h0;
        AData = 32'h0; BData = 32'h0;
        ex_RW = 1'b0; ex_DA = 5'd0; ex_MD = 2'b00; ex_result = 32'h0;
        wb_RW = 1'b0; wb_DA = 5'd0; wb_result = 32'h0;
        flush = 1'b0; stall_in = 1'b0;
        c_rw = 1'b0; c_da = 5'd0; c_md = 2'b00; c_bs = 2'b00; c_ps = 1'b0; c_mw = 1'b0;
        c_fs = 5'd0; c_ma = 1'b0; c_mb = 1'b0; c_cs = 1'b0; c_aa = 5'd0; c_ba = 5'd0;
        pack_ctrl();
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mw = 0; m_ps = 0; m_known = 1;
        m_pc = 0; m_busa = 0; m_busb = 0; m_da = 0; m_fs = 0; m_sh = 0;
        m_md = 0; m_bs = 0; m_cnt = 0;
    endtask

    // Immediate value from the low 15 bits: signed reading when CS=1.
    function automatic logic [31:0] ref_imm();
        logic [31:0] v;
        v = {17'd0, instruction[14:0]};
        if (c_cs && instruction[14]) v = v - 32'h8000;
        return v;
    endfunction

    function automatic logic [31:0] ref_operand(input logic use_alt, input logic [31:0] alt,
                                                input logic [4:0] r, input logic [31:0] rf);
        if (use_alt) return alt;
        if (r != 0 && ex_RW && ex_DA == r && ex_MD != 2'b01) return ex_result;
        if (r != 0 && wb_RW && wb_DA == r) return wb_result;
        return rf;
    endfunction

    // One clock: combinational checks, model update at the edge, registered checks.
    task automatic step();
        logic        e_lus;
        logic [31:0] e_a, e_b;
        #1;
        e_lus = in_valid && ex_RW && ex_MD == 2'b01 && ex_DA != 0 &&
                ((ex_DA == c_aa && !c_ma) || (ex_DA == c_ba && !c_mb));
        chk("load_use_stall", load_use_stall, e_lus);
        chk("in_ready", in_ready, !stall_in && !e_lus);
        chk("AA", AA, c_aa);
        chk("BA", BA, c_ba);
        e_a = ref_operand(c_ma, pc_min_one, c_aa, AData);
        e_b = ref_operand(c_mb, ref_imm(), c_ba, BData);
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mw = 0; m_known = 0;
        end else if (stall_in) begin
            // nothing moves
        end else if (e_lus) begin
            m_valid = 0; m_rw = 0; m_mw = 0; m_known = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_valid = in_valid; m_rw = in_valid & c_rw; m_mw = in_valid & c_mw;
            m_pc = pc_min_one; m_da = c_da; m_md = c_md; m_bs = c_bs; m_ps = c_ps;
            m_fs = c_fs; m_sh = instruction[4:0]; m_busa = e_a; m_busb = e_b;
            m_known = 1;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("RW", RW, m_rw);
        chk("MW", MW, m_mw);
        chk("bubble_count", bubble_count, m_cnt);
        if (m_known) begin
            chk("pc_min_two", pc_min_two, m_pc);
            chk("DA", DA, m_da);
            chk("MD", MD, m_md);
            chk("BS", BS, m_bs);
            chk("PS", PS, m_ps);
            chk("FS", FS, m_fs);
            chk("SH", SH, m_sh);
            chk("BUSA", BUSA, m_busa);
            chk("BUSB", BUSB, m_busb);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_regs"}, {RW, MW, PS, DA, MD, BS, FS, SH}, 0);
        chk({tag, "_pc"}, pc_min_two, 0);
        chk({tag, "_busa"}, BUSA, 0);
        chk({tag, "_busb"}, BUSB, 0);
        chk({tag, "_bubble_count"}, bubble_count, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Forward from EX
        clear_inputs();
        ex_RW = 1; ex_DA = 5'd3; ex_MD = 2'b00; ex_result = 32'h55;
        c_aa = 5'd3; AData = 32'h11; c_rw = 1; c_da = 5'd9; pack_ctrl();
        step();
        chk("fwd_ex_busa", BUSA, 32'h55);

        // EX beats WB on the same register
        clear_inputs();
        ex_RW = 1; ex_DA = 5'd7; ex_result = 32'hA;
        wb_RW = 1; wb_DA = 5'd7; wb_result = 32'hB;
        c_ba = 5'd7; BData = 32'h77; pack_ctrl();
        step();
        chk("ex_over_wb_busb", BUSB, 32'hA);

        // Register 0 never forwarded and never stalls
        clear_inputs();
        ex_RW = 1; ex_DA = 5'd0; ex_MD = 2'b01; ex_result = 32'h123;
        wb_RW = 1; wb_DA = 5'd0; wb_result = 32'h99;
        pack_ctrl();
        #1;
        chk("r0_no_stall", load_use_stall, 0);
        step();
        chk("r0_busa", BUSA, 32'h0);

        // Load-use: one bubble, then accepted
        clear_inputs();
        ex_RW = 1; ex_DA = 5'd4; ex_MD = 2'b01;
        c_aa = 5'd4; c_rw = 1; c_mw = 1; AData = 32'h44; pack_ctrl();
        #1;
        chk("lu_in_ready", in_ready, 0);
        step();
        chk("lu_bubble_valid", out_valid, 0);
        chk("lu_bubble_count", bubble_count, 16'd1);
        ex_MD = 2'b00; ex_result = 32'h4444;
        step();
        chk("lu_accept_valid", out_valid, 1);
        chk("lu_accept_busa", BUSA, 32'h4444);

        // Flush wins over stall
        flush = 1; stall_in = 1;
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_rw_mw", {RW, MW}, 2'b00);

        // Immediate extension
        clear_inputs();
        c_mb = 1; c_cs = 1; instruction = 32'h0000_4000; pack_ctrl();
        step();
        chk("imm_sext", BUSB, 32'hFFFF_C000);
        c_cs = 0; pack_ctrl();
        step();
        chk("imm_zext", BUSB, 32'h0000_4000);

        // Reset while stalled discards the held instruction
        clear_inputs();
        c_rw = 1; c_fs = 5'd5; pc_min_one = 32'hABCD; AData = 32'h5; pack_ctrl();
        step();
        stall_in = 1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all_zero("reset_stall");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            in_valid    = $urandom_range(0, 3) != 0;
            instruction = $urandom;
            pc_min_one  = $urandom;
            AData = $urandom; BData = $urandom;
            ex_RW = $urandom_range(0, 1); ex_DA = 5'($urandom_range(0, 7));
            ex_MD = 2'($urandom_range(0, 3)); ex_result = $urandom;
            wb_RW = $urandom_range(0, 1); wb_DA = 5'($urandom_range(0, 7));
            wb_result = $urandom;
            flush    = $urandom_range(0, 9) == 0;
            stall_in = $urandom_range(0, 4) == 0;
            c_rw = $urandom_range(0, 1); c_da = 5'($urandom_range(0, 31));
            c_md = 2'($urandom_range(0, 3)); c_bs = 2'($urandom_range(0, 3));
            c_ps = $urandom_range(0, 1); c_mw = $urandom_range(0, 1);
            c_fs = 5'($urandom_range(0, 31));
            c_ma = $urandom_range(0, 3) == 0; c_mb = $urandom_range(0, 3) == 0;
            c_cs = $urandom_range(0, 1);
            c_aa = 5'($urandom_range(0, 7)); c_ba = 5'($urandom_range(0, 7));
            pack_ctrl();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dof_stage.md
DOF_STAGE -- requirements
Module: dof_stage

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 32, meaning operand and PC width.
REQ-002 The block SHALL have parameter INSTRUCTION_BITS, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter REG_ADDR_BITS, default 5, meaning register address and shift width.
REQ-004 The block SHALL have parameter IMM_BITS, default 15, meaning immediate field width, taken from instruction[IMM_BITS-1:0].
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- instruction  in  INSTRUCTION_BITS  raw instruction.
- pc_min_one  in  DATA_BITS  PC of the instruction.
- ctrl_in  in  CTRL_BITS  packed decoder fields RW, DA, MD, BS, PS, MW, FS, MA, MB, CS, AA, BA.
- AData, BData  in  DATA_BITS  register-file read data.
- ex_RW, ex_DA, ex_MD, ex_result  in  1/REG_ADDR_BITS/2/DATA_BITS  execute-stage writeback info.
- wb_RW, wb_DA, wb_result  in  1/REG_ADDR_BITS/DATA_BITS  writeback-stage info.
- flush  in  1  kill the instruction in this stage.
- stall_in  in  1  downstream hold.
- AA, BA  out  REG_ADDR_BITS  combinational register-file read addresses.
- out_valid  out  1  registered outputs hold a live instruction.
- pc_min_two, RW, DA, MD, BS, PS, MW, FS, SH, BUSA, BUSB  out  registered pipeline outputs.
- load_use_stall  out  1  combinational bubble request.
- bubble_count  out  16  saturating count of load-use bubbles.

Function
REQ-006 The extended immediate SHALL be the sign-extension of IM to DATA_BITS when CS=1, and the zero-extension when CS=0.
REQ-007 SH SHALL capture instruction[REG_ADDR_BITS-1:0].
REQ-008 Operand A SHALL select as follows, highest priority first:
- MA=1 -> pc_min_one.
- ex_RW and ex_DA==AA and AA!=0 and ex_MD!=MD_LOAD -> ex_result.
- wb_RW and wb_DA==AA and AA!=0 -> wb_result.
- otherwise -> AData.
REQ-009 Operand B SHALL follow the same rule, with MB=1 selecting the extended immediate and BA/BData used in place of AA/AData.
REQ-010 load_use_stall SHALL equal in_valid and ex_RW and ex_MD==MD_LOAD and ex_DA!=0 and ((ex_DA==AA and !MA) or (ex_DA==BA and !MB)).
REQ-011 in_ready SHALL equal !stall_in and !load_use_stall.
REQ-012 Each rising edge SHALL apply exactly one of these actions, in priority order:
- flush -> out_valid, RW and MW all 0.
- stall_in -> every output register holds.
- load_use_stall -> bubble: out_valid, RW and MW all 0; other outputs don't-care.
- otherwise -> capture all fields; out_valid takes in_valid.
REQ-013 When a capture occurs with in_valid=0, RW and MW SHALL be 0.
REQ-014 Latency SHALL be exactly one cycle from acceptance to out_valid.
REQ-015 bubble_count SHALL increment on each bubble cycle that is not overridden by flush or stall_in, and SHALL saturate at 16'hFFFF.
REQ-016 Flush and load-use in the same cycle SHALL produce the flush result and SHALL NOT count a bubble.

Reset
REQ-017 While rst_n=0, the block SHALL asynchronously clear all registered outputs, out_valid and bubble_count to 0; registers SHALL update again from the first rising edge after release.
REQ-018 Reset asserted mid-stall SHALL discard the held instruction.

Structure
REQ-019 Package dof_pkg SHALL hold the CTRL_BITS value, the ctrl_in field offsets and widths, and MD_LOAD=2'b01.
REQ-020 Forwarding selection SHALL be a sub-module, dof_operand_mux, instantiated once per operand.

Verification
REQ-021 Verification SHALL cover these scenarios:
- Forward from EX: ex_RW=1, ex_DA=3, ex_MD=00, ex_result=0x55, AA=3, AData=0x11 -> BUSA=0x55 next cycle.
- EX over WB priority: EX and WB both target BA=7 (0xA, 0xB), MB=0 -> BUSB=0xA.
- Register 0: ex_DA=0, AA=0, AData=0 -> BUSA=0; no load_use_stall.
- Load-use: ex_MD=01, ex_DA=4, AA=4 -> in_ready=0; next cycle out_valid=0 and bubble_count=1; instruction accepted one cycle later.
- Flush with stall_in=1 -> out_valid=0 and RW=MW=0; then immediate, CS=1, IM=15'h4000 -> BUSB=0xFFFFC000; CS=0 -> 0x00004000.
- Reset during stall -> all outputs 0 and bubble_count=0.
